id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: id_valid in 1; id_rs1, id_rs2, id_rd in 5 each; id_uses_rs1, id_uses_rs2 in 1 each (operand actually read).
REQ-004 SHALL have ports: id_reg_write, id_mem_read, id_mem_write in 1 each; id_alu_op in 4; id_rs1_data, id_rs2_data, id_imm, id_pc in 32 each.
REQ-005 SHALL have ports: wb_reg_write in 1; wb_rd in 5; wb_data in 32 (regfile write-through source).
REQ-006 SHALL have ports: ex_stall in 1 (EX busy, hold); flush in 1 (taken branch resolved in EX).
REQ-007 SHALL have outputs: id_ex_valid 1; id_ex_rs1, id_ex_rs2, id_ex_rd 5; id_ex_reg_write, id_ex_mem_read, id_ex_mem_write 1; id_ex_alu_op 4; id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_pc 32.
REQ-008 SHALL have outputs: stall_id 1 (hold PC and IF/ID); bubble_count 16 (load-use bubbles inserted).

Function
REQ-009 SHALL be a registered ID/EX pipeline stage with one entry; all id_ex_* outputs come straight from flops.
REQ-010 SHALL flag load_use when id_ex_valid=1, id_ex_mem_read=1, id_ex_rd!=0, id_valid=1, and (id_uses_rs1 and id_rs1==id_ex_rd, or id_uses_rs2 and id_rs2==id_ex_rd).
REQ-011 SHALL drive stall_id = ex_stall OR (load_use AND NOT flush), combinationally.
REQ-012 SHALL apply per-edge priority: ex_stall > flush > load_use > capture.
REQ-013 SHALL hold every id_ex_* flop unchanged while ex_stall=1; a simultaneous flush SHALL be ignored, and the source reasserts it.
REQ-014 SHALL, on flush with ex_stall=0, load a bubble at the next edge.
REQ-015 SHALL, on load_use with ex_stall=0 and flush=0, load a bubble at the next edge; bubble_count then increments.
REQ-016 SHALL define a bubble as: id_ex_valid=0; rs1, rs2 and rd=0; reg_write, mem_read and mem_write=0; alu_op=0; data, imm and pc fields hold their previous values.
REQ-017 SHALL otherwise capture ID inputs; id_ex_valid=id_valid; control bits and register indices are ANDed/zeroed with id_valid.
REQ-018 SHALL, during capture, substitute wb_data for id_rs1_data when wb_reg_write=1, wb_rd!=0 and wb_rd==id_rs1; likewise for rs2 independently.
REQ-019 SHALL give a load_use-inserted bubble exactly one cycle of duration; the next edge captures the held ID instruction, since the load has left EX.
REQ-020 SHALL stretch load-use across ex_stall: stall_id stays high and no bubble is inserted until ex_stall drops.
REQ-021 SHALL have bubble_count increment by 1 per inserted load-use bubble, saturate at 16'hFFFF, and never count flush bubbles.
REQ-022 SHALL have latency of exactly 1 cycle, ID input to id_ex_* output, when not stalled.

Reset
REQ-023 SHALL, with rst_n=0, immediately and asynchronously force all id_ex_* outputs to 0 (the valid register and all data), bubble_count to 0, and stall_id to its combinational value with id_ex_valid=0.
REQ-024 SHALL, on reset mid-stall, discard the held instruction; the first edge after release captures normally.

Verification
REQ-025 Load-use: EX holds valid load rd=5; ID instr uses rs1=5 -> stall_id=1 one cycle, bubble (valid=0, rd=0) next edge, then instr captured, bubble_count=1.
REQ-026 No false stall: load rd=0 with ID rs1=0, or load rd=5 with id_uses_rs2=0 and rs2=5 -> stall_id=0, no bubble.
REQ-027 WB write-through: wb_rd=3, wb_data=32'hDEADBEEF, id_rs2=3, id_rs2_data=0 -> id_ex_rs2_data=32'hDEADBEEF; wb_rd=0 -> no substitution.
REQ-028 Priority: ex_stall=1 and flush=1 together -> outputs held; flush alone next cycle -> bubble, bubble_count unchanged; load_use and flush together -> flush bubble, stall_id=0.
REQ-029 Saturation: force 65536 load-use bubbles -> bubble_count=16'hFFFF, holds.
REQ-030 Async reset: assert rst_n=0 between edges while id_ex_valid=1 -> outputs go 0 before the next clk edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and WB write-through.
// Latency: 1 cycle from ID inputs to id_ex_* outputs when not stalled.
// Backpressure: ex_stall freezes the register; stall_id holds PC and IF/ID during ex_stall or a load-use hazard.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_*                       decoded instruction from the ID stage
//   wb_reg_write/wb_rd/wb_data register file write in flight (write-through source)
//   ex_stall, flush            EX busy (hold) / taken branch resolved in EX (squash)
//   id_ex_*                    registered instruction presented to EX
//   stall_id                   hold request to the front end
//   bubble_count               saturating count of load-use bubbles inserted
module id_ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  id_rd,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic [3:0]  id_alu_op,
   input  logic [31:0] id_rs1_data,
   input  logic [31:0] id_rs2_data,
   input  logic [31:0] id_imm,
   input  logic [31:0] id_pc,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        ex_stall,
   input  logic        flush,
   output logic        id_ex_valid,
   output logic [4:0]  id_ex_rs1,
   output logic [4:0]  id_ex_rs2,
   output logic [4:0]  id_ex_rd,
   output logic        id_ex_reg_write,
   output logic        id_ex_mem_read,
   output logic        id_ex_mem_write,
   output logic [3:0]  id_ex_alu_op,
   output logic [31:0] id_ex_rs1_data,
   output logic [31:0] id_ex_rs2_data,
   output logic [31:0] id_ex_imm,
   output logic [31:0] id_ex_pc,
   output logic        stall_id,
   output logic [15:0] bubble_count
);

   logic        load_use;
   logic        rs1_hit;
   logic        rs2_hit;
   logic        wb_fwd_rs1;
   logic        wb_fwd_rs2;
   logic [31:0] rs1_data_in;
   logic [31:0] rs2_data_in;

   // A load in EX whose destination the ID instruction actually reads.
   assign rs1_hit  = id_uses_rs1 && (id_rs1 == id_ex_rd);
   assign rs2_hit  = id_uses_rs2 && (id_rs2 == id_ex_rd);
   assign load_use = id_ex_valid && id_ex_mem_read && (id_ex_rd != 5'd0) &&
                     id_valid && (rs1_hit || rs2_hit);

   // A flush kills the dependent instruction, so there is nothing to hold for.
   assign stall_id = ex_stall || (load_use && !flush);

   // The register file is written this same edge; take the new value directly.
   assign wb_fwd_rs1  = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs1);
   assign wb_fwd_rs2  = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs2);
   assign rs1_data_in = wb_fwd_rs1 ? wb_data : id_rs1_data;
   assign rs2_data_in = wb_fwd_rs2 ? wb_data : id_rs2_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_ex_valid     <= 1'b0;
         id_ex_rs1       <= 5'd0;
         id_ex_rs2       <= 5'd0;
         id_ex_rd        <= 5'd0;
         id_ex_reg_write <= 1'b0;
         id_ex_mem_read  <= 1'b0;
         id_ex_mem_write <= 1'b0;
         id_ex_alu_op    <= 4'd0;
         id_ex_rs1_data  <= 32'd0;
         id_ex_rs2_data  <= 32'd0;
         id_ex_imm       <= 32'd0;
         id_ex_pc        <= 32'd0;
         bubble_count    <= 16'd0;
      end else if (ex_stall) begin
         // Hold everything; a concurrent flush is dropped and the branch unit
         // reasserts it once EX frees up.
      end else if (flush || load_use) begin
         // Bubble: kill control and indices, leave the data fields as they were.
         id_ex_valid     <= 1'b0;
         id_ex_rs1       <= 5'd0;
         id_ex_rs2       <= 5'd0;
         id_ex_rd        <= 5'd0;
         id_ex_reg_write <= 1'b0;
         id_ex_mem_read  <= 1'b0;
         id_ex_mem_write <= 1'b0;
         id_ex_alu_op    <= 4'd0;
         // Only load-use bubbles are counted; flush takes priority.
         if (!flush && (bubble_count != 16'hFFFF)) begin
            bubble_count <= bubble_count + 16'd1;
         end
      end else begin
         id_ex_valid     <= id_valid;
         id_ex_rs1       <= id_rs1 & {5{id_valid}};
         id_ex_rs2       <= id_rs2 & {5{id_valid}};
         id_ex_rd        <= id_rd & {5{id_valid}};
         id_ex_reg_write <= id_reg_write & id_valid;
         id_ex_mem_read  <= id_mem_read & id_valid;
         id_ex_mem_write <= id_mem_write & id_valid;
         id_ex_alu_op    <= id_alu_op & {4{id_valid}};
         id_ex_rs1_data  <= rs1_data_in;
         id_ex_rs2_data  <= rs2_data_in;
         id_ex_imm       <= id_imm;
         id_ex_pc        <= id_pc;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_uses_rs1, id_uses_rs2;
   logic        id_reg_write, id_mem_read, id_mem_write;
   logic [3:0]  id_alu_op;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        ex_stall, flush;
   logic        id_ex_valid;
   logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
   logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
   logic [3:0]  id_ex_alu_op;
   logic [31:0] id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_pc;
   logic        stall_id;
   logic [15:0] bubble_count;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_alu_op(id_alu_op), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_pc(id_pc),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_stall(ex_stall), .flush(flush),
      .id_ex_valid(id_ex_valid), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
      .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
      .id_ex_mem_write(id_ex_mem_write), .id_ex_alu_op(id_ex_alu_op),
      .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
      .id_ex_imm(id_ex_imm), .id_ex_pc(id_ex_pc),
      .stall_id(stall_id), .bubble_count(bubble_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one decoded instruction on the ID inputs.
   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic rw, input logic mr, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] pc);
      id_valid     = v;
      id_rs1       = rs1;
      id_rs2       = rs2;
      id_rd        = rd;
      id_uses_rs1  = u1;
      id_uses_rs2  = u2;
      id_reg_write = rw;
      id_mem_read  = mr;
      id_mem_write = 1'b0;
      id_alu_op    = 4'h3;
      id_rs1_data  = d1;
      id_rs2_data  = d2;
      id_imm       = pc + 32'h1000;
      id_pc        = pc;
   endtask

   initial begin
      rst_n        = 1'b0;
      wb_reg_write = 1'b0;
      wb_rd        = 5'd0;
      wb_data      = 32'd0;
      ex_stall     = 1'b0;
      flush        = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

      // Reset state
      tick();
      tick();
      chk("rst_valid", {31'd0, id_ex_valid}, 32'd0);
      chk("rst_cnt", {16'd0, bubble_count}, 32'd0);
      chk("rst_stall", {31'd0, stall_id}, 32'd0);
      rst_n = 1'b1;

      // Plain capture, one cycle latency
      set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 32'd11, 32'd22, 32'h100);
      tick();
      chk("cap_valid", {31'd0, id_ex_valid}, 32'd1);
      chk("cap_rd", {27'd0, id_ex_rd}, 32'd7);
      chk("cap_rs1d", id_ex_rs1_data, 32'd11);
      chk("cap_alu", {28'd0, id_ex_alu_op}, 32'd3);
      chk("cap_imm", id_ex_imm, 32'h1100);

      // Load-use: load rd=5 into EX, dependent instruction in ID
      set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'h104);
      tick();
      chk("ld_mr", {31'd0, id_ex_mem_read}, 32'd1);
      set_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 32'd55, 32'd0, 32'h108);
      #1;
      chk("lu_stall", {31'd0, stall_id}, 32'd1);
      tick();
      chk("lu_bub_valid", {31'd0, id_ex_valid}, 32'd0);
      chk("lu_bub_rd", {27'd0, id_ex_rd}, 32'd0);
      chk("lu_bub_pc_held", id_ex_pc, 32'h104);
      chk("lu_cnt1", {16'd0, bubble_count}, 32'd1);
      chk("lu_stall_off", {31'd0, stall_id}, 32'd0);
      tick();
      chk("lu_cap_valid", {31'd0, id_ex_valid}, 32'd1);
      chk("lu_cap_rd", {27'd0, id_ex_rd}, 32'd6);
      chk("lu_cap_pc", id_ex_pc, 32'h108);

      // No false stall: load to x0, then unused rs2 matching a load rd
      set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'h10C);
      tick();
      set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'h110);
      #1;
      chk("nf_rd0_stall", {31'd0, stall_id}, 32'd0);
      tick();
      chk("nf_rd0_valid", {31'd0, id_ex_valid}, 32'd1);
      chk("nf_ld5_rd", {27'd0, id_ex_rd}, 32'd5);
      set_id(1'b1, 5'd4, 5'd5, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'h114);
      #1;
      chk("nf_rs2_stall", {31'd0, stall_id}, 32'd0);
      tick();
      chk("nf_rs2_rd", {27'd0, id_ex_rd}, 32'd8);
      chk("nf_cnt", {16'd0, bubble_count}, 32'd1);

      // WB write-through on rs2, then no substitution for wb_rd=0
      set_id(1'b1, 5'd1, 5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1111, 32'd0, 32'h118);
      wb_reg_write = 1'b1;
      wb_rd        = 5'd3;
      wb_data      = 32'hDEADBEEF;
      tick();
      chk("wb_rs2", id_ex_rs2_data, 32'hDEADBEEF);
      chk("wb_rs1_untouched", id_ex_rs1_data, 32'h1111);
      set_id(1'b1, 5'd1, 5'd0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1111, 32'h22, 32'h200);
      wb_rd = 5'd0;
      tick();
      chk("wb_rd0_nosub", id_ex_rs2_data, 32'h22);
      wb_reg_write = 1'b0;

      // Priority: stall + flush holds, then flush alone bubbles without counting
      set_id(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'h300);
      ex_stall = 1'b1;
      flush    = 1'b1;
      #1;
      chk("pr_stall_id", {31'd0, stall_id}, 32'd1);
      tick();
      chk("pr_hold_rd", {27'd0, id_ex_rd}, 32'd10);
      chk("pr_hold_pc", id_ex_pc, 32'h200);
      chk("pr_hold_valid", {31'd0, id_ex_valid}, 32'd1);
      ex_stall = 1'b0;
      tick();
      chk("fl_valid", {31'd0, id_ex_valid}, 32'd0);
      chk("fl_rw", {31'd0, id_ex_reg_write}, 32'd0);
      chk("fl_pc_held", id_ex_pc, 32'h200);
      chk("fl_cnt", {16'd0, bubble_count}, 32'd1);
      flush = 1'b0;
      set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'h304);
      tick();
      set_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'h308);
      flush = 1'b1;
      #1;
      chk("lufl_stall", {31'd0, stall_id}, 32'd0);
      tick();
      chk("lufl_valid", {31'd0, id_ex_valid}, 32'd0);
      chk("lufl_cnt", {16'd0, bubble_count}, 32'd1);
      flush = 1'b0;

      // Load-use stretched across ex_stall
      set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'h400);
      tick();
      set_id(1'b1, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'h404);
      ex_stall = 1'b1;
      tick();
      chk("lus_hold_mr", {31'd0, id_ex_mem_read}, 32'd1);
      chk("lus_cnt", {16'd0, bubble_count}, 32'd1);
      chk("lus_stall", {31'd0, stall_id}, 32'd1);
      ex_stall = 1'b0;
      #1;
      chk("lus_stall2", {31'd0, stall_id}, 32'd1);
      tick();
      chk("lus_bub", {31'd0, id_ex_valid}, 32'd0);
      chk("lus_cnt2", {16'd0, bubble_count}, 32'd2);
      tick();
      chk("lus_cap_pc", id_ex_pc, 32'h404);

      // Saturation: preload the counter near the top, then drive load-use bubbles
      force dut.bubble_count = 16'hFFFE;
      #1;
      release dut.bubble_count;
      set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'h500);
      tick();
      set_id(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'h504);
      tick();
      chk("sat_ffff", {16'd0, bubble_count}, 32'h0000FFFF);
      tick();
      chk("sat_cap_mr", {31'd0, id_ex_mem_read}, 32'd1);
      tick();
      chk("sat_bub", {31'd0, id_ex_valid}, 32'd0);
      chk("sat_hold", {16'd0, bubble_count}, 32'h0000FFFF);

      // Async reset mid-stall, between edges
      set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 32'hA, 32'hB, 32'h600);
      tick();
      chk("ar_pre_valid", {31'd0, id_ex_valid}, 32'd1);
      ex_stall = 1'b1;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", {31'd0, id_ex_valid}, 32'd0);
      chk("ar_rd", {27'd0, id_ex_rd}, 32'd0);
      chk("ar_pc", id_ex_pc, 32'd0);
      chk("ar_rs1d", id_ex_rs1_data, 32'd0);
      chk("ar_cnt", {16'd0, bubble_count}, 32'd0);
      #1;
      rst_n    = 1'b1;
      ex_stall = 1'b0;
      set_id(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 32'hC, 32'hD, 32'h700);
      tick();
      chk("ar_post_rd", {27'd0, id_ex_rd}, 32'd11);
      chk("ar_post_pc", id_ex_pc, 32'h700);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
